// File: rtl/stream_arb_mux.sv
// stream_arb_mux: N-to-1 packet-aware stream arbiter with a single registered
// output stage. Grants are round-robin or fixed-priority. A grant is held for
// the full length of a multi-beat packet.

// Binary index to one-hot decoder used to steer the data path.
module bin_to_1h #(
    parameter int bin_width = 2,
    parameter int out_width = 3
) (
    input  logic [bin_width-1:0] bin_i,
    output logic [out_width-1:0] onehot_o
);

    // Decode: bit i is set when the binary index equals i.
    always_comb begin
        onehot_o = '0;
        for (int i = 0; i < out_width; i++) begin
            onehot_o[i] = (bin_i == bin_width'(i));
        end
    end

endmodule

// One-hot AND-OR multiplexer: the selected lane passes, all-zero select gives 0.
module mux_1h #(
    parameter int num   = 3,
    parameter int width = 32
) (
    input  logic [num-1:0]       sel_i,
    input  logic [num*width-1:0] data_i,
    output logic [width-1:0]     data_o
);

    // OR together every lane masked by its select bit.
    always_comb begin
        data_o = '0;
        for (int i = 0; i < num; i++) begin
            data_o = data_o | ({width{sel_i[i]}} & data_i[i*width +: width]);
        end
    end

endmodule

module stream_arb_mux #(
    parameter int num_port     = 3,
    parameter int data_width   = 32,
    parameter int select_width = $clog2(num_port),
    parameter int round_robin  = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [num_port-1:0]            in_valid,
    output logic [num_port-1:0]            in_ready,
    input  logic [num_port*data_width-1:0] in_data,
    input  logic [num_port-1:0]            in_last,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [data_width-1:0]          out_data,
    output logic                           out_last,
    output logic [select_width-1:0]        out_select
);

    // One extra bit so (last_grant + offset) can exceed num_port before wrapping.
    localparam int WIDE = select_width + 1;

    // Arbitration state.
    logic                    lock_q, lock_d;
    logic [select_width-1:0] lock_ch_q, lock_ch_d;
    logic [select_width-1:0] last_grant_q, last_grant_d;

    // Output register stage.
    logic                    out_valid_q, out_valid_d;
    logic [data_width-1:0]   out_data_q, out_data_d;
    logic                    out_last_q, out_last_d;
    logic [select_width-1:0] out_select_q, out_select_d;

    // Combinational arbitration and data path.
    logic [select_width-1:0] rr_grant_s;
    logic [select_width-1:0] fp_grant_s;
    logic [select_width-1:0] grant_s;
    logic [num_port-1:0]     grant_1h_s;
    logic [num_port-1:0]     ready_s;
    logic [data_width-1:0]   sel_data_s;
    logic                    sel_last_s;
    logic                    load_en_s;
    logic                    xfer_s;

    // Round-robin search: first valid channel starting just after the last
    // completed packet's channel, wrapping modulo num_port so the index never
    // reaches an unused encoding when num_port is not a power of two.
    always_comb begin : rr_search
        logic [WIDE-1:0]         cand;
        logic [WIDE-1:0]         wrapped;
        logic [select_width-1:0] idx;
        logic                    found;
        logic                    hit;
        rr_grant_s = '0;
        found      = 1'b0;
        cand       = '0;
        wrapped    = '0;
        idx        = '0;
        hit        = 1'b0;
        for (int k = 0; k < num_port; k++) begin
            cand       = {1'b0, last_grant_q} + WIDE'(k + 1);
            wrapped    = (cand >= WIDE'(num_port)) ? (cand - WIDE'(num_port)) : cand;
            idx        = wrapped[select_width-1:0];
            hit        = !found && in_valid[idx];
            rr_grant_s = hit ? idx : rr_grant_s;
            found      = found || hit;
        end
    end

    // Fixed priority search: lowest-index valid channel wins.
    always_comb begin : fp_search
        logic found;
        logic hit;
        fp_grant_s = '0;
        found      = 1'b0;
        hit        = 1'b0;
        for (int k = 0; k < num_port; k++) begin
            hit        = !found && in_valid[k];
            fp_grant_s = hit ? select_width'(k) : fp_grant_s;
            found      = found || hit;
        end
    end

    // Grant choice: a locked packet keeps its channel even when that channel
    // is momentarily idle; otherwise the configured arbitration policy decides.
    always_comb begin
        if (lock_q) begin
            grant_s = lock_ch_q;
        end else if (round_robin != 0) begin
            grant_s = rr_grant_s;
        end else begin
            grant_s = fp_grant_s;
        end
    end

    // The output register can take a beat when empty or draining this cycle.
    assign load_en_s = !reset && (!out_valid_q || out_ready);

    bin_to_1h #(
        .bin_width (select_width),
        .out_width (num_port)
    ) u_grant_dec (
        .bin_i    (grant_s),
        .onehot_o (grant_1h_s)
    );

    // At most one ready bit, since grant_1h_s is one-hot.
    assign ready_s  = {num_port{load_en_s}} & grant_1h_s & in_valid;
    assign in_ready = ready_s;
    assign xfer_s   = |ready_s;

    mux_1h #(
        .num   (num_port),
        .width (data_width)
    ) u_data_mux (
        .sel_i  (grant_1h_s),
        .data_i (in_data),
        .data_o (sel_data_s)
    );

    mux_1h #(
        .num   (num_port),
        .width (1)
    ) u_last_mux (
        .sel_i  (grant_1h_s),
        .data_i (in_last),
        .data_o (sel_last_s)
    );

    // Next-state: load a new beat on input transfer (replacing any draining
    // beat), clear valid on a drain with no refill, otherwise hold everything.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_last_d   = out_last_q;
        out_select_d = out_select_q;
        lock_d       = lock_q;
        lock_ch_d    = lock_ch_q;
        last_grant_d = last_grant_q;
        if (xfer_s) begin
            out_valid_d  = 1'b1;
            out_data_d   = sel_data_s;
            out_last_d   = sel_last_s;
            out_select_d = grant_s;
            lock_d       = !sel_last_s;
            lock_ch_d    = grant_s;
            last_grant_d = sel_last_s ? grant_s : last_grant_q;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State and output registers with synchronous reset; last_grant resets to
    // the top channel so the first round-robin search begins at channel 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
            out_select_q <= '0;
            lock_q       <= 1'b0;
            lock_ch_q    <= '0;
            last_grant_q <= select_width'(num_port - 1);
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
            out_select_q <= out_select_d;
            lock_q       <= lock_d;
            lock_ch_q    <= lock_ch_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_last   = out_last_q;
    assign out_select = out_select_q;

endmodule

// File: tb/tb_stream_arb_mux.sv
// Bench for stream_arb_mux: three instances (3-port RR, 3-port fixed priority,
// 5-port RR) are checked every cycle against a packet-level reference model,
// with directed scenarios whose key outputs are also pinned to literals.
module tb_stream_arb_mux;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        started;
    logic [4:0]  v    [3];
    logic [4:0]  l    [3];
    logic [31:0] d    [3][5];
    logic        ordy [3];

    int n_checks = 0;
    int n_pass   = 0;

    // DUT-side signals
    logic [2:0]  a_rdy, b_rdy;
    logic [4:0]  c_rdy;
    logic        a_ov, b_ov, c_ov;
    logic [31:0] a_od, b_od, c_od;
    logic        a_ol, b_ol, c_ol;
    logic [1:0]  a_os, b_os;
    logic [2:0]  c_os;

    stream_arb_mux #(.num_port(3), .data_width(32), .round_robin(1)) u_rr3 (
        .clk(clk), .reset(reset),
        .in_valid(v[0][2:0]), .in_ready(a_rdy),
        .in_data({d[0][2], d[0][1], d[0][0]}), .in_last(l[0][2:0]),
        .out_valid(a_ov), .out_ready(ordy[0]),
        .out_data(a_od), .out_last(a_ol), .out_select(a_os)
    );

    stream_arb_mux #(.num_port(3), .data_width(32), .round_robin(0)) u_fp3 (
        .clk(clk), .reset(reset),
        .in_valid(v[1][2:0]), .in_ready(b_rdy),
        .in_data({d[1][2], d[1][1], d[1][0]}), .in_last(l[1][2:0]),
        .out_valid(b_ov), .out_ready(ordy[1]),
        .out_data(b_od), .out_last(b_ol), .out_select(b_os)
    );

    stream_arb_mux #(.num_port(5), .data_width(32), .round_robin(1)) u_rr5 (
        .clk(clk), .reset(reset),
        .in_valid(v[2]), .in_ready(c_rdy),
        .in_data({d[2][4], d[2][3], d[2][2], d[2][1], d[2][0]}), .in_last(l[2]),
        .out_valid(c_ov), .out_ready(ordy[2]),
        .out_data(c_od), .out_last(c_ol), .out_select(c_os)
    );

    // Uniform views of the three instances
    logic [4:0]  rdy [3];
    logic        ov  [3];
    logic [31:0] od  [3];
    logic        ol  [3];
    logic [2:0]  os  [3];

    always_comb begin
        rdy[0] = {2'b00, a_rdy}; rdy[1] = {2'b00, b_rdy}; rdy[2] = c_rdy;
        ov[0]  = a_ov;  ov[1] = b_ov;  ov[2] = c_ov;
        od[0]  = a_od;  od[1] = b_od;  od[2] = c_od;
        ol[0]  = a_ol;  ol[1] = b_ol;  ol[2] = c_ol;
        os[0]  = {1'b0, a_os}; os[1] = {1'b0, b_os}; os[2] = c_os;
    end

    // Reference model: packet-level view of each arbiter
    int np   [3] = '{3, 3, 5};
    bit isrr [3] = '{1'b1, 1'b0, 1'b1};
    logic        m_ov   [3];
    logic [31:0] m_od   [3];
    logic        m_ol   [3];
    int          m_os   [3];
    bit          m_lock [3];
    int          m_lch  [3];
    int          m_lg   [3];

    // Channel that transfers this cycle, or -1 if none.
    function automatic int pick(int k);
        int res;
        int c;
        res = -1;
        if (reset || (m_ov[k] && !ordy[k])) return -1;
        if (m_lock[k]) return v[k][m_lch[k]] ? m_lch[k] : -1;
        for (int j = 0; j < np[k]; j++) begin
            c = isrr[k] ? (m_lg[k] + 1 + j) % np[k] : j;
            if (res < 0 && v[k][c]) res = c;
        end
        return res;
    endfunction

    function automatic logic [4:0] exp_ready(int k);
        int p;
        p = pick(k);
        return (p >= 0) ? (5'b00001 << p) : 5'b00000;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (reset) begin
                m_ov[k] <= 1'b0; m_od[k] <= 32'h0; m_ol[k] <= 1'b0; m_os[k] <= 0;
                m_lock[k] <= 1'b0; m_lch[k] <= 0; m_lg[k] <= np[k] - 1;
            end else if (pick(k) >= 0) begin
                m_ov[k] <= 1'b1;
                m_od[k] <= d[k][pick(k)];
                m_ol[k] <= l[k][pick(k)];
                m_os[k] <= pick(k);
                if (l[k][pick(k)]) begin
                    m_lock[k] <= 1'b0;
                    m_lg[k]   <= pick(k);
                end else begin
                    m_lock[k] <= 1'b1;
                    m_lch[k]  <= pick(k);
                end
            end else if (ordy[k]) begin
                m_ov[k] <= 1'b0;
            end
        end
    end

    task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s[%0d]: got 0x%0h expected 0x%0h", name, k, act, exp);
    endtask

    // Per-cycle comparison of every instance against the model
    always @(negedge clk) begin
        if (started) begin
            for (int k = 0; k < 3; k++) begin
                check("in_ready",   k, {27'd0, rdy[k]}, {27'd0, exp_ready(k)});
                check("out_valid",  k, {31'd0, ov[k]},  {31'd0, m_ov[k]});
                check("out_data",   k, od[k],           m_od[k]);
                check("out_last",   k, {31'd0, ol[k]},  {31'd0, m_ol[k]});
                check("out_select", k, {29'd0, os[k]},  m_os[k]);
                check("sel_range",  k, {31'd0, (32'(os[k]) < np[k])}, 32'd1);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        for (int k = 0; k < 3; k++) begin
            v[k] = 5'b0; l[k] = 5'b0; ordy[k] = 1'b1;
            for (int i = 0; i < 5; i++) d[k][i] = 32'h1000 * (k + 1) + 32'(i);
        end
    endtask

    task automatic reset_pulse();
        reset = 1'b1;
        clear_inputs();
        step(1);
        reset = 1'b0;
    endtask

    initial begin
        started = 1'b0;
        reset   = 1'b1;
        clear_inputs();
        @(posedge clk); #1;
        started = 1'b1;
        check("rst_valid",  0, {31'd0, ov[0]}, 32'd0);
        check("rst_ready",  0, {27'd0, rdy[0]}, 32'd0);
        check("rst_lgrant", 2, {31'd0, ov[2]}, 32'd0);
        step(1);
        reset = 1'b0;

        // RR rotation on inst0; fixed priority ch0 over ch2 on inst1
        v[0] = 5'b00111; l[0] = 5'b00111;
        v[1] = 5'b00101; l[1] = 5'b00111;
        for (int i = 0; i < 6; i++) begin
            step(1);
            check("rr_seq",     0, {29'd0, os[0]}, 32'(i % 3));
            check("rr_valid",   0, {31'd0, ov[0]}, 32'd1);
            check("fp_sel",     1, {29'd0, os[1]}, 32'd0);
            check("fp_ch2_rdy", 1, {31'd0, rdy[1][2]}, 32'd0);
        end

        // Multi-beat packet on ch1 locks the grant, including an idle gap
        reset_pulse();
        v[0] = 5'b00001; l[0] = 5'b00111;
        step(1);
        check("pkt_pre", 0, {29'd0, os[0]}, 32'd0);
        v[0] = 5'b00111; l[0] = 5'b00101;
        step(1);
        check("pkt_b1",      0, {29'd0, os[0]}, 32'd1);
        check("pkt_b1_last", 0, {31'd0, ol[0]}, 32'd0);
        step(1);
        check("pkt_b2", 0, {29'd0, os[0]}, 32'd1);
        v[0] = 5'b00101;
        #1;
        check("lock_idle_rdy", 0, {27'd0, rdy[0]}, 32'd0);
        step(1);
        check("lock_idle_ov", 0, {31'd0, ov[0]}, 32'd0);
        v[0] = 5'b00111; l[0] = 5'b00111;
        step(1);
        check("pkt_b3",      0, {29'd0, os[0]}, 32'd1);
        check("pkt_b3_last", 0, {31'd0, ol[0]}, 32'd1);
        step(1);
        check("pkt_next2", 0, {29'd0, os[0]}, 32'd2);
        step(1);
        check("pkt_next0", 0, {29'd0, os[0]}, 32'd0);

        // Backpressure hold, then drain and refill in the same cycle
        reset_pulse();
        d[0][0] = 32'hDEADBEEF; v[0] = 5'b00001; l[0] = 5'b00001;
        step(1);
        check("bp_load", 0, od[0], 32'hDEADBEEF);
        ordy[0] = 1'b0; d[0][0] = 32'h11111111;
        for (int i = 0; i < 4; i++) begin
            step(1);
            check("bp_hold",  0, od[0], 32'hDEADBEEF);
            check("bp_valid", 0, {31'd0, ov[0]}, 32'd1);
            check("bp_rdy",   0, {27'd0, rdy[0]}, 32'd0);
        end
        ordy[0] = 1'b1;
        #1;
        check("bp_refill_rdy", 0, {27'd0, rdy[0]}, 32'd1);
        step(1);
        check("bp_refill", 0, od[0], 32'h11111111);
        check("bp_refill_ov", 0, {31'd0, ov[0]}, 32'd1);

        // Reset in the middle of a ch2 packet
        reset_pulse();
        v[0] = 5'b00100; l[0] = 5'b00000;
        step(2);
        check("mid_pkt_sel", 0, {29'd0, os[0]}, 32'd2);
        reset = 1'b1; v[0] = 5'b00111; l[0] = 5'b00111;
        step(1);
        check("rst_mid_ov",  0, {31'd0, ov[0]}, 32'd0);
        check("rst_mid_rdy", 0, {27'd0, rdy[0]}, 32'd0);
        reset = 1'b0;
        #1;
        check("post_rst_rdy", 0, {27'd0, rdy[0]}, 32'd1);
        step(1);
        check("post_rst_sel", 0, {29'd0, os[0]}, 32'd0);

        // Five-port wrap 4 -> 0
        reset_pulse();
        v[2] = 5'b10000; l[2] = 5'b11111;
        step(1);
        check("wrap_4", 2, {29'd0, os[2]}, 32'd4);
        v[2] = 5'b10001;
        step(1);
        check("wrap_0", 2, {29'd0, os[2]}, 32'd0);
        step(1);
        check("wrap_4b", 2, {29'd0, os[2]}, 32'd4);
        step(1);
        check("wrap_0b", 2, {29'd0, os[2]}, 32'd0);

        clear_inputs();
        step(3);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
